// File: rtl/inst_sequencer_pkg.sv
// Shared constants for the instruction sequencer: sizes, FSM encoding, opcodes.
package inst_sequencer_pkg;

  localparam int SEQ_INST_W = 64;
  localparam int SEQ_DEPTH  = 16;
  localparam int SEQ_ADDR_W = 4;
  localparam int SEQ_CNT_W  = 8;
  localparam int SEQ_DRAIN  = 6;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } seq_state_e;

  // Opcodes live in inst[31:29]; shared with the PE-array decoder.
  localparam logic [2:0] OP_LOAD   = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b001;
  localparam logic [2:0] OP_SUB    = 3'b010;
  localparam logic [2:0] OP_MUL    = 3'b011;
  localparam logic [2:0] OP_MULADD = 3'b100;
  localparam logic [2:0] OP_RELU   = 3'b101;
  localparam logic [2:0] OP_MIN    = 3'b110;
  localparam logic [2:0] OP_MAX    = 3'b111;

  // Extract the opcode field of an instruction word.
  function automatic logic [2:0] seq_opcode(input logic [SEQ_INST_W-1:0] inst);
    return inst[31:29];
  endfunction

endpackage

// File: rtl/inst_sequencer_ram.sv
// Program store: simple dual-port RAM, one write and one synchronous read port,
// no reset so it maps onto LUTRAM.
module inst_ram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port and registered read port; read data holds when re is low.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/inst_sequencer.sv
// Instruction fetch/issue stage: replays a host-loaded program a number of
// times as an inst_v/inst stream, waits for the decoder pipeline to drain,
// then pulses done.
//
// Issue is a two-stage pipe: RUN reads mem[pc] into the RAM read register
// (issue_q marks that slot valid), and the next edge moves it into the
// output registers. stall only gates the first stage, so there is no
// combinational path from stall to any output.
module inst_sequencer
  import inst_sequencer_pkg::*;
#(
  parameter int INST_WIDTH = SEQ_INST_W,
  parameter int DEPTH      = SEQ_DEPTH,
  parameter int ADDR_W     = SEQ_ADDR_W,
  parameter int CNT_W      = SEQ_CNT_W,
  parameter int DRAIN_CYC  = SEQ_DRAIN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  prog_we,
  input  logic [ADDR_W-1:0]     prog_addr,
  input  logic [INST_WIDTH-1:0] prog_data,
  input  logic                  start,
  input  logic [ADDR_W:0]       num_inst,
  input  logic [CNT_W-1:0]      loops,
  input  logic                  stall,
  output logic                  busy,
  output logic                  done,
  output logic                  inst_v,
  output logic [INST_WIDTH-1:0] inst
);

  localparam int LEN_W = ADDR_W + 1;
  localparam int DRN_W = $clog2(DRAIN_CYC + 1);
  localparam logic [LEN_W-1:0] DEPTH_L  = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [CNT_W-1:0] LOOP_ONE = CNT_W'(1);
  localparam logic [DRN_W-1:0] DRN_END  = DRN_W'(DRAIN_CYC);

  seq_state_e state_q, state_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [CNT_W-1:0]      loop_q, loop_d;
  logic [DRN_W-1:0]      drain_q, drain_d;
  logic                  issue_q, issue_d;
  logic                  inst_v_q, inst_v_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  ram_we;
  logic                  ram_re;
  logic [INST_WIDTH-1:0] ram_rdata;
  logic [LEN_W-1:0]      len_clamped;
  logic                  pc_at_last;

  inst_ram #(
    .DATA_W (INST_WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (ram_re),
    .raddr (pc_q),
    .rdata (ram_rdata)
  );

  assign len_clamped = (num_inst > DEPTH_L) ? DEPTH_L : num_inst;
  assign pc_at_last  = ({1'b0, pc_q} == (len_q - LEN_ONE));

  // Next-state, datapath and output register inputs.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    len_d    = len_q;
    loop_d   = loop_q;
    drain_d  = drain_q;
    issue_d  = 1'b0;
    inst_v_d = issue_q;
    inst_d   = issue_q ? ram_rdata : inst_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ram_we   = 1'b0;
    ram_re   = 1'b0;

    case (state_q)
      S_IDLE: begin
        ram_we = prog_we;
        if (start) begin
          len_d   = len_clamped;
          loop_d  = (loops == '0) ? LOOP_ONE : loops;
          pc_d    = '0;
          drain_d = '0;
          busy_d  = 1'b1;
          state_d = (len_clamped == '0) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (!stall) begin
          ram_re  = 1'b1;
          issue_d = 1'b1;
          if (pc_at_last) begin
            pc_d = '0;
            // Exit is checked before the decrement, so loop_q never reaches 0.
            if (loop_q == LOOP_ONE) begin
              state_d = S_DRAIN;
            end else begin
              loop_d = loop_q - LOOP_ONE;
            end
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
        end
      end
      S_DRAIN: begin
        // Count only once the last fetched word has left the read stage.
        if (!issue_q) begin
          if (drain_q == DRN_END) begin
            state_d = S_FIN;
          end else begin
            drain_d = drain_q + DRN_W'(1);
          end
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      loop_q   <= '0;
      drain_q  <= '0;
      issue_q  <= 1'b0;
      inst_v_q <= 1'b0;
      inst_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      loop_q   <= loop_d;
      drain_q  <= drain_d;
      issue_q  <= issue_d;
      inst_v_q <= inst_v_d;
      inst_q   <= inst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign inst_v = inst_v_q;
  assign inst   = inst_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: cycle tables for the timed runs plus
// hand-written sequences for reset, busy protection and full-depth replay.
module tb_inst_sequencer;
  import inst_sequencer_pkg::*;

  localparam int IW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          prog_we = 1'b0;
  logic [3:0]    prog_addr = '0;
  logic [IW-1:0] prog_data = '0;
  logic          start = 1'b0;
  logic [4:0]    num_inst = '0;
  logic [7:0]    loops = '0;
  logic          stall = 1'b0;
  logic          busy, done, inst_v;
  logic [IW-1:0] inst;

  int errors = 0;
  int checks = 0;

  logic [IW-1:0] prog [16];
  logic [IW-1:0] exp_q [$];

  typedef struct {
    logic          stall;
    logic          start;
    logic          we;
    logic          exp_v;
    logic          chk_inst;
    logic [IW-1:0] exp_inst;
    logic          exp_busy;
    logic          exp_done;
  } row_t;

  row_t tbl [$];

  inst_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .start     (start),
    .num_inst  (num_inst),
    .loops     (loops),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .inst_v    (inst_v),
    .inst      (inst)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mk_inst(input logic [2:0] op, input int idx);
    logic [31:0] hi;
    logic [28:0] lo;
    hi = 32'h1000_0000 + 32'(idx) * 32'h0101_0101;
    lo = 29'(idx + 7);
    return {hi, op, lo};
  endfunction

  task automatic check(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [IW-1:0] data);
    prog_we   = 1'b1;
    prog_addr = 4'(addr);
    prog_data = data;
    step();
    prog_we   = 1'b0;
  endtask

  // Present start for one edge; returns just after that edge (row k=0).
  task automatic kick(input logic [4:0] n, input logic [7:0] l);
    start    = 1'b1;
    num_inst = n;
    loops    = l;
    step();
    start    = 1'b0;
  endtask

  function automatic row_t mk_row(input logic s, input logic v, input logic ci,
                                  input logic [IW-1:0] ei, input logic b, input logic d);
    row_t r;
    r.stall = s; r.start = 1'b0; r.we = 1'b0;
    r.exp_v = v; r.chk_inst = ci; r.exp_inst = ei;
    r.exp_busy = b; r.exp_done = d;
    return r;
  endfunction

  // Row k is checked after edge t+k, then its inputs are driven for edge t+k+1.
  task automatic run_table(input string tag);
    for (int k = 0; k < tbl.size(); k++) begin
      check($sformatf("%s k%0d inst_v", tag, k), IW'(inst_v), IW'(tbl[k].exp_v));
      check($sformatf("%s k%0d busy", tag, k), IW'(busy), IW'(tbl[k].exp_busy));
      check($sformatf("%s k%0d done", tag, k), IW'(done), IW'(tbl[k].exp_done));
      if (tbl[k].chk_inst) begin
        check($sformatf("%s k%0d inst", tag, k), inst, tbl[k].exp_inst);
      end
      stall     = tbl[k].stall;
      start     = tbl[k].start;
      prog_we   = tbl[k].we;
      prog_addr = 4'd0;
      prog_data = 64'hDEAD;
      if (tbl[k].start) begin
        num_inst = 5'd2;
        loops    = 8'd3;
      end
      step();
    end
    stall = 1'b0; start = 1'b0; prog_we = 1'b0;
  endtask

  // 4-instruction single pass: issues at k=2..5, done at k=13.
  task automatic build_basic(input logic intrude);
    tbl.delete();
    for (int k = 0; k < 15; k++) begin
      logic v;
      logic [IW-1:0] ei;
      v  = (k >= 2 && k <= 5);
      ei = v ? prog[k-2] : prog[3];
      tbl.push_back(mk_row(1'b0, v, (k >= 2), ei, (k <= 12), (k == 13)));
    end
    if (intrude) begin
      tbl[1].start = 1'b1;
      tbl[1].we    = 1'b1;
    end
  endtask

  // Bounded monitor for long runs: scoreboard every issue, count done pulses.
  task automatic monitor(input string tag, input int cycles, output int issues, output int dones);
    issues = 0;
    dones  = 0;
    for (int c = 0; c < cycles; c++) begin
      if (inst_v) begin
        issues++;
        if (exp_q.size() == 0) begin
          check({tag, " extra issue"}, IW'(1), IW'(0));
        end else begin
          check($sformatf("%s issue%0d", tag, issues - 1), inst, exp_q.pop_front());
        end
      end
      if (done) dones++;
      step();
    end
  endtask

  initial begin
    int issues;
    int dones;

    prog[0] = mk_inst(OP_ADD, 0);
    prog[1] = mk_inst(OP_SUB, 1);
    prog[2] = mk_inst(OP_MUL, 2);
    prog[3] = mk_inst(OP_MULADD, 3);
    for (int i = 4; i < 16; i++) prog[i] = mk_inst(3'(i), i);

    // Reset state
    step(); step();
    check("reset busy", IW'(busy), IW'(0));
    check("reset done", IW'(done), IW'(0));
    check("reset inst_v", IW'(inst_v), IW'(0));
    check("reset inst", inst, '0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 4; i++) load(i, prog[i]);

    // 1. Basic run
    build_basic(1'b0);
    kick(5'd4, 8'd1);
    run_table("basic");
    check("basic opcode0", IW'(seq_opcode(prog[0])), IW'(OP_ADD));

    // 2. Loop and stall (stall at k=10,11 falls in DRAIN and is ignored)
    tbl.delete();
    for (int k = 0; k < 19; k++) begin
      logic v;
      logic [IW-1:0] ei;
      v = (k == 2 || k == 3 || (k >= 6 && k <= 9));
      case (k)
        2: ei = prog[0];
        3, 4, 5: ei = prog[1];
        6: ei = prog[2];
        7: ei = prog[0];
        8: ei = prog[1];
        default: ei = prog[2];
      endcase
      tbl.push_back(mk_row((k == 2 || k == 3 || k == 10 || k == 11), v, (k >= 2), ei,
                           (k <= 16), (k == 17)));
    end
    kick(5'd3, 8'd2);
    run_table("loopstall");

    // 3. Zero length: done DRAIN_CYC+2 edges after start
    tbl.delete();
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk_row(1'b0, 1'b0, 1'b0, '0, (k <= 7), (k == 8)));
    kick(5'd0, 8'd5);
    run_table("zero");

    // 4. Busy protection, then replay to confirm mem[0] untouched
    build_basic(1'b1);
    kick(5'd4, 8'd1);
    run_table("busyprot");
    build_basic(1'b0);
    kick(5'd4, 8'd1);
    run_table("afterprot");

    // 5. Reset mid-run
    kick(5'd4, 8'd3);
    step(); step();
    check("midrun inst_v before reset", IW'(inst_v), IW'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async rst inst_v", IW'(inst_v), IW'(0));
    check("async rst busy", IW'(busy), IW'(0));
    check("async rst inst", inst, '0);
    check("async rst done", IW'(done), IW'(0));
    step(); step();
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (done || inst_v || busy) dones++;
      step();
    end
    check("post-reset quiet", IW'(dones), IW'(0));
    build_basic(1'b0);
    kick(5'd4, 8'd1);
    run_table("afterrst");

    // 6. Full depth, loops=0 treated as 1
    for (int i = 4; i < 16; i++) load(i, prog[i]);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(prog[i]);
    kick(5'd16, 8'd0);
    monitor("full", 60, issues, dones);
    check("full issues", IW'(issues), IW'(16));
    check("full dones", IW'(dones), IW'(1));
    check("full busy end", IW'(busy), IW'(0));

    // num_inst above DEPTH clamps to DEPTH; two loops check the wrap at 15
    exp_q.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 16; i++) exp_q.push_back(prog[i]);
    kick(5'd20, 8'd2);
    monitor("clamp", 80, issues, dones);
    check("clamp issues", IW'(issues), IW'(32));
    check("clamp dones", IW'(dones), IW'(1));
    check("clamp busy end", IW'(busy), IW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
